// File: rtl/spi_responder.sv
// SPI responder (mode CPOL/CPHA=0) with a 64x8 register file and a local access port.
// Define SPI_RESPONDER_AUTOINC_EN to enable multi-byte bursts with address auto-increment.
module spi_responder #(
    parameter logic CPOL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_CLK,
    input  logic       SPI_CS,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [5:0] usr_addr,
    input  logic       usr_we,
    input  logic [7:0] usr_wdata,
    output logic [7:0] usr_rdata,
    output logic       busy,
    output logic       wr_valid,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic [1:0] sync_fill;
    logic       armed;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       lead_edge;
    logic       trail_edge;
    logic       cs_fall;
    logic       byte_done;
    logic       spi_we;
    logic [7:0] rx_byte;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] miso_sr;
    logic       load_pending;
    logic       rw;
    logic       byte_active;
    logic [5:0] addr;
`ifdef SPI_RESPONDER_AUTOINC_EN
    logic       mb;
`endif

    logic [7:0] mem [64];

    assign sclk_s     = sclk_sync[1];
    assign cs_s       = cs_sync[1];
    assign mosi_s     = mosi_sync[1];
    assign lead_edge  = (sclk_prev != sclk_s) && (sclk_s != CPOL);
    assign trail_edge = (sclk_prev != sclk_s) && (sclk_s == CPOL);
    assign cs_fall    = cs_prev && !cs_s;
    assign rx_byte    = {rx_sr[6:0], mosi_s};
    assign byte_done  = lead_edge && (bit_cnt == 3'd7) && !cs_s &&
                        ((state == CMD) || (state == DATA));
    assign spi_we     = byte_done && (state == DATA) && !rw && byte_active;

    assign SPI_MISO = miso_sr[7];
    assign busy     = (state != IDLE);

    // armed stays low after reset until CS has really been seen high, so a frame
    // interrupted by reset is never picked up halfway through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= {2{CPOL}};
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SPI_CLK};
            cs_sync   <= {cs_sync[0], SPI_CS};
            mosi_sync <= {mosi_sync[0], SPI_MOSI};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (armed && cs_fall) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each completed byte arms a load; the next trailing edge loads MISO with
    // the byte for the address that is now current.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= 3'd0;
            rx_sr        <= 8'h00;
            miso_sr      <= 8'h00;
            load_pending <= 1'b0;
            rw           <= 1'b0;
            byte_active  <= 1'b0;
            addr         <= 6'd0;
`ifdef SPI_RESPONDER_AUTOINC_EN
            mb           <= 1'b0;
`endif
        end else if ((state == IDLE) || cs_s) begin
            bit_cnt      <= 3'd0;
            load_pending <= 1'b0;
            miso_sr      <= 8'h00;
        end else if (lead_edge) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                load_pending <= 1'b1;
                if (state == CMD) begin
                    rw          <= rx_byte[7];
                    addr        <= rx_byte[5:0];
                    byte_active <= 1'b1;
`ifdef SPI_RESPONDER_AUTOINC_EN
                    mb          <= rx_byte[6];
`endif
                end else begin
`ifdef SPI_RESPONDER_AUTOINC_EN
                    byte_active <= byte_active && mb;
                    addr        <= addr + 6'd1;
`else
                    byte_active <= 1'b0;
`endif
                end
            end
        end else if (trail_edge) begin
            if (load_pending) begin
                miso_sr      <= (rw && byte_active) ? mem[addr] : 8'h00;
                load_pending <= 1'b0;
            end else begin
                miso_sr <= {miso_sr[6:0], 1'b0};
            end
        end
    end

    // The SPI write is issued last so it wins over a same-cycle local write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (usr_we) begin
                mem[usr_addr] <= usr_wdata;
            end
            if (spi_we) begin
                mem[addr] <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            usr_rdata <= 8'h00;
            wr_valid  <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'h00;
        end else begin
            usr_rdata <= mem[usr_addr];
            wr_valid  <= spi_we;
            if (spi_we) begin
                wr_addr <= addr;
                wr_data <= rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Directed testbench for spi_responder; burst expectations follow SPI_RESPONDER_AUTOINC_EN.
module tb_spi_responder;

    localparam int HALF = 8;
`ifdef SPI_RESPONDER_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic [5:0] usr_addr;
    logic       usr_we;
    logic [7:0] usr_wdata;
    logic [7:0] usr_rdata;
    logic       busy;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         wr_count = 0;
    int         wr_before;
    logic [5:0] wr_last_addr = 6'd0;
    logic [7:0] wr_last_data = 8'h00;
    logic [7:0] rx;
    logic [7:0] rx2;
    logic [7:0] rd;

    spi_responder #(.CPOL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SPI_CLK   (spi_clk),
        .SPI_CS    (spi_cs),
        .SPI_MOSI  (spi_mosi),
        .SPI_MISO  (spi_miso),
        .usr_addr  (usr_addr),
        .usr_we    (usr_we),
        .usr_wdata (usr_wdata),
        .usr_rdata (usr_rdata),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            wr_count     <= wr_count + 1;
            wr_last_addr <= wr_addr;
            wr_last_data <= wr_data;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // action 1: same-cycle local write to address 9 on the final leading edge;
    // action 2: local write to address 0x12 in the middle of the byte.
    task automatic applyStimulus(input logic [7:0] tx, input int nbits, input int action,
                                 output logic [7:0] rx_out);
        rx_out = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clks(HALF);
            rx_out[i] = spi_miso;
            spi_clk = 1'b1;
            if (i == 0 && action == 1) begin
                wait_clks(2);
                usr_addr  = 6'd9;
                usr_wdata = 8'hAA;
                usr_we    = 1'b1;
                wait_clks(1);
                usr_we = 1'b0;
                checkOutput("collide_wr_valid", 8'(wr_valid), 8'h01);
                wait_clks(HALF - 3);
            end else if (i == 4 && action == 2) begin
                wait_clks(2);
                usr_addr  = 6'h12;
                usr_wdata = 8'hC3;
                usr_we    = 1'b1;
                wait_clks(1);
                usr_we = 1'b0;
                wait_clks(HALF - 3);
            end else begin
                wait_clks(HALF);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(HALF);
        spi_cs = 1'b1;
        wait_clks(6);
    endtask

    task automatic usr_read(input logic [5:0] a, output logic [7:0] d);
        usr_addr = a;
        wait_clks(1);
        d = usr_rdata;
    endtask

    initial begin
        rst_n     = 1'b0;
        spi_clk   = 1'b0;
        spi_cs    = 1'b1;
        spi_mosi  = 1'b0;
        usr_addr  = 6'd0;
        usr_we    = 1'b0;
        usr_wdata = 8'h00;
        wait_clks(3);
        checkOutput("reset_miso", 8'(spi_miso), 8'h00);
        checkOutput("reset_busy", 8'(busy), 8'h00);
        checkOutput("reset_wr_valid", 8'(wr_valid), 8'h00);
        checkOutput("reset_wr_addr", 8'(wr_addr), 8'h00);
        checkOutput("reset_wr_data", wr_data, 8'h00);
        checkOutput("reset_usr_rdata", usr_rdata, 8'h00);
        rst_n = 1'b1;
        wait_clks(4);

        // Single-byte write to address 5
        wr_before = wr_count;
        cs_low();
        checkOutput("write_busy", 8'(busy), 8'h01);
        applyStimulus(8'h05, 8, 0, rx);
        applyStimulus(8'hA5, 8, 0, rx);
        checkOutput("write_miso_zero", rx, 8'h00);
        cs_high();
        checkOutput("write_pulses", 8'(wr_count - wr_before), 8'h01);
        checkOutput("write_wr_addr", 8'(wr_last_addr), 8'h05);
        checkOutput("write_wr_data", wr_last_data, 8'hA5);
        checkOutput("write_idle_busy", 8'(busy), 8'h00);
        usr_read(6'd5, rd);
        checkOutput("write_usr_rdata", rd, 8'hA5);

        // Local write then SPI read of address 0x12
        usr_addr  = 6'h12;
        usr_wdata = 8'h3C;
        usr_we    = 1'b1;
        wait_clks(1);
        usr_we = 1'b0;
        wr_before = wr_count;
        cs_low();
        applyStimulus(8'h92, 8, 0, rx);
        checkOutput("read_cmd_miso_zero", rx, 8'h00);
        applyStimulus(8'h00, 8, 0, rx);
        checkOutput("read_data", rx, 8'h3C);
        cs_high();
        checkOutput("read_no_wr", 8'(wr_count - wr_before), 8'h00);
        checkOutput("read_miso_idle", 8'(spi_miso), 8'h00);

        // Local write during an in-flight read must not disturb the shifted byte
        cs_low();
        applyStimulus(8'h92, 8, 0, rx);
        applyStimulus(8'h00, 8, 2, rx);
        checkOutput("inflight_data", rx, 8'h3C);
        cs_high();
        usr_read(6'h12, rd);
        checkOutput("inflight_local_write", rd, 8'hC3);

        // Abort mid-byte
        wr_before = wr_count;
        cs_low();
        applyStimulus(8'h07, 8, 0, rx);
        applyStimulus(8'hFF, 4, 0, rx);
        spi_cs = 1'b1;
        wait_clks(3);
        checkOutput("abort_busy", 8'(busy), 8'h00);
        wait_clks(4);
        checkOutput("abort_no_wr", 8'(wr_count - wr_before), 8'h00);
        usr_read(6'd7, rd);
        checkOutput("abort_reg7", rd, 8'h00);

        // Burst write and read across the 63 -> 0 wrap
        wr_before = wr_count;
        cs_low();
        applyStimulus(8'h7F, 8, 0, rx);
        applyStimulus(8'h11, 8, 0, rx);
        applyStimulus(8'h22, 8, 0, rx);
        cs_high();
        checkOutput("burst_pulses", 8'(wr_count - wr_before), AUTOINC ? 8'h02 : 8'h01);
        usr_read(6'd63, rd);
        checkOutput("burst_reg63", rd, 8'h11);
        usr_read(6'd0, rd);
        checkOutput("burst_reg0", rd, AUTOINC ? 8'h22 : 8'h00);
        cs_low();
        applyStimulus(8'hFF, 8, 0, rx);
        applyStimulus(8'h00, 8, 0, rx);
        applyStimulus(8'h00, 8, 0, rx2);
        cs_high();
        checkOutput("burst_read0", rx, 8'h11);
        checkOutput("burst_read1", rx2, AUTOINC ? 8'h22 : 8'h00);

        // SPI write and local write hit address 9 in the same cycle
        cs_low();
        applyStimulus(8'h09, 8, 0, rx);
        applyStimulus(8'h55, 8, 1, rx);
        cs_high();
        checkOutput("collide_wr_data", wr_last_data, 8'h55);
        usr_read(6'd9, rd);
        checkOutput("collide_reg9", rd, 8'h55);

        // Reset in the middle of a data byte
        cs_low();
        applyStimulus(8'h0A, 8, 0, rx);
        applyStimulus(8'hFF, 4, 0, rx);
        rst_n = 1'b0;
        wait_clks(1);
        checkOutput("midreset_miso", 8'(spi_miso), 8'h00);
        checkOutput("midreset_busy", 8'(busy), 8'h00);
        checkOutput("midreset_wr_valid", 8'(wr_valid), 8'h00);
        checkOutput("midreset_wr_addr", 8'(wr_addr), 8'h00);
        checkOutput("midreset_wr_data", wr_data, 8'h00);
        checkOutput("midreset_usr_rdata", usr_rdata, 8'h00);
        rst_n = 1'b1;
        usr_read(6'd5, rd);
        checkOutput("midreset_reg5_cleared", rd, 8'h00);
        wr_before = wr_count;
        applyStimulus(8'h0D, 8, 0, rx);
        applyStimulus(8'h77, 8, 0, rx);
        checkOutput("midreset_stale_busy", 8'(busy), 8'h00);
        cs_high();
        checkOutput("midreset_stale_no_wr", 8'(wr_count - wr_before), 8'h00);
        wr_before = wr_count;
        cs_low();
        applyStimulus(8'h0B, 8, 0, rx);
        applyStimulus(8'h66, 8, 0, rx);
        cs_high();
        checkOutput("postreset_pulses", 8'(wr_count - wr_before), 8'h01);
        usr_read(6'd11, rd);
        checkOutput("postreset_reg11", rd, 8'h66);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
